// File: rtl/sram_block_fetch.sv
// sram_block_fetch: streams BLOCK_DIM x BLOCK_DIM coefficient blocks from SRAM into a block buffer.
// Define SRAM_BLOCK_FETCH_PINGPONG_EN to double-buffer (fetch one block ahead into the other bank).
module sram_block_fetch #(
    parameter int BLOCK_DIM      = 8,
    parameter int ADDR_W         = 18,
    parameter int DATA_W         = 16,
    parameter int SRAM_LATENCY   = 2,
    parameter int IMG_STRIDE     = 320,
    parameter int BLOCKS_PER_ROW = 40,
    parameter int BLOCK_ROWS     = 30
) (
    input  logic                                  Clock,
    input  logic                                  Reset,
    input  logic                                  Enable,
    input  logic [ADDR_W-1:0]                     Base_address,
    output logic [ADDR_W-1:0]                     SRAM_address,
    input  logic [DATA_W-1:0]                     SRAM_read_data,
    output logic                                  SRAM_we_n,
    output logic [$clog2(BLOCK_DIM*BLOCK_DIM):0]  Buf_address,
    output logic [31:0]                           Buf_write_data,
    output logic                                  Buf_we,
    output logic                                  Block_ready,
    input  logic                                  Consumer_ack,
    output logic                                  Busy,
    output logic                                  Done
);
    localparam int N  = BLOCK_DIM * BLOCK_DIM;
    localparam int IW = $clog2(N);
    localparam int LB = $clog2(BLOCK_DIM);
    localparam int CW = $clog2(BLOCKS_PER_ROW);
    localparam int RW = $clog2(BLOCK_ROWS);
    localparam int L  = SRAM_LATENCY;
`ifdef SRAM_BLOCK_FETCH_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WAIT_ACK, NEXT_BLOCK, DONE} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q;
    logic [RW-1:0]     br_q;
    logic [CW-1:0]     bc_q;
    logic [ADDR_W-1:0] base_q, addr;
    logic              bank_q, pend_q, shown_q, rdy_q, rdy_d;
    logic [L-1:0]      vld_q;
    logic [IW:0]       badr_q [L];
    logic              ack_ok, fin, last_blk;

    // pend_q: a block has been announced but not yet acknowledged by the consumer
    assign ack_ok   = Consumer_ack && pend_q && !rdy_q;
    assign fin      = vld_q[L-1] && badr_q[L-1][IW-1:0] == IW'(N-1);
    assign last_blk = br_q == RW'(BLOCK_ROWS-1) && bc_q == CW'(BLOCKS_PER_ROW-1);
    assign addr     = base_q + ADDR_W'(br_q) * ADDR_W'(BLOCK_DIM*IMG_STRIDE)
                    + ADDR_W'(bc_q) * ADDR_W'(BLOCK_DIM)
                    + ADDR_W'(idx_q[IW-1:LB]) * ADDR_W'(IMG_STRIDE)
                    + ADDR_W'(idx_q[LB-1:0]);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            br_q    <= '0;
            bc_q    <= '0;
            base_q  <= '0;
            bank_q  <= 1'b0;
            pend_q  <= 1'b0;
            shown_q <= 1'b0;
            rdy_q   <= 1'b0;
            vld_q   <= '0;
            for (int i = 0; i < L; i++) badr_q[i] <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            shown_q <= state_d == WAIT_ACK && (shown_q || rdy_d);
            pend_q  <= rdy_d || (pend_q && !ack_ok);
            if (state_q == IDLE && Enable) begin
                base_q <= Base_address;
                idx_q  <= '0;
                br_q   <= '0;
                bc_q   <= '0;
                bank_q <= 1'b0;
            end
            if (state_q == ISSUE) idx_q <= idx_q + 1'b1;
            if (state_q == NEXT_BLOCK) begin
                bank_q <= bank_q ^ PP;
                if (bc_q == CW'(BLOCKS_PER_ROW-1)) begin
                    bc_q <= '0;
                    br_q <= br_q + 1'b1;
                end else begin
                    bc_q <= bc_q + 1'b1;
                end
            end
            vld_q[0]  <= state_q == ISSUE;
            badr_q[0] <= {bank_q, idx_q};
            for (int i = 1; i < L; i++) begin
                vld_q[i]  <= vld_q[i-1];
                badr_q[i] <= badr_q[i-1];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rdy_d   = 1'b0;
        case (state_q)
            IDLE:       if (Enable) state_d = ISSUE;
            ISSUE:      if (idx_q == IW'(N-1)) state_d = DRAIN;
            DRAIN:      if (fin) begin
                            state_d = WAIT_ACK;
                            rdy_d   = !pend_q || ack_ok;
                        end
            WAIT_ACK:   if (!shown_q) rdy_d = ack_ok;
                        else if (!PP || last_blk) begin
                            if (ack_ok) state_d = last_blk ? DONE : NEXT_BLOCK;
                        end else state_d = NEXT_BLOCK;
            NEXT_BLOCK: state_d = ISSUE;
            DONE:       state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        SRAM_address   = state_q == ISSUE ? addr : '0;
        SRAM_we_n      = 1'b1;
        Buf_we         = vld_q[L-1];
        Buf_address    = Buf_we ? badr_q[L-1] : '0;
        Buf_write_data = Buf_we ? {{(32-DATA_W){SRAM_read_data[DATA_W-1]}}, SRAM_read_data} : 32'd0;
        Block_ready    = rdy_q;
        Busy           = state_q != IDLE;
        Done           = state_q == DONE;
    end
endmodule

// File: tb/tb_sram_block_fetch.sv
// tb_sram_block_fetch: directed bench for sram_block_fetch (3-row grid to keep the full run short).
module tb_sram_block_fetch;
    logic        Clock = 1'b0, Reset = 1'b1, Enable = 1'b0, Consumer_ack = 1'b0;
    logic [17:0] Base_address = 18'd76800;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_read_data = 16'hFF80;
    logic        SRAM_we_n, Buf_we, Block_ready, Busy, Done;
    logic [6:0]  Buf_address;
    logic [31:0] Buf_write_data;
    int          total = 0, bad = 0;

    sram_block_fetch #(.BLOCK_ROWS(3)) dut (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .Base_address(Base_address),
        .SRAM_address(SRAM_address), .SRAM_read_data(SRAM_read_data), .SRAM_we_n(SRAM_we_n),
        .Buf_address(Buf_address), .Buf_write_data(Buf_write_data), .Buf_we(Buf_we),
        .Block_ready(Block_ready), .Consumer_ack(Consumer_ack), .Busy(Busy), .Done(Done)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic ack;
        tick;
        Consumer_ack = 1'b1;
        tick;
        Consumer_ack = 1'b0;
    endtask

    task automatic fetch(output logic [17:0] first, output logic [17:0] last, output int nwe, output int niss);
        bit got = 0;
        first = '0; last = '0; nwe = 0; niss = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            tick;
            if (SRAM_address != 0) begin
                if (niss == 0) first = SRAM_address;
                last = SRAM_address;
                niss++;
            end
            if (Buf_we) nwe++;
            if (Block_ready) got = 1;
        end
        if (!got) check("ready_timeout", 0, 1);
    endtask

    initial begin
        logic [17:0] first, last;
        int nwe, niss, rdy_at, cnt, pa;
        bit flag, seen;
        tick;
        tick;
        Reset = 1'b0;
        check("rst_busy", Busy, 0);
        check("rst_addr", SRAM_address, 0);
        check("rst_we_n", SRAM_we_n, 1);
        check("rst_bufwe", Buf_we, 0);
        check("rst_rdy_done", {Block_ready, Done}, 0);
        Enable = 1'b1;
        nwe = 0; rdy_at = -1;
        for (int k = 0; k < 67; k++) begin
            tick;
            Enable = 1'b0;
            if (k == 0) check("busy_run", Busy, 1);
            if (k < 8) check($sformatf("addr%0d", k), SRAM_address, 76800 + k);
            if (k == 8) check("addr_row1", SRAM_address, 77120);
            if (k == 63) check("addr_last", SRAM_address, 79047);
            if (Buf_we) nwe++;
            if (Block_ready && rdy_at < 0) rdy_at = k;
            if (k == 2) begin
                check("sext_neg", Buf_write_data, 32'hFFFFFF80);
                check("bufaddr0", Buf_address, 0);
                SRAM_read_data = 16'h007F;
            end
            if (k == 3) begin
                check("sext_pos", Buf_write_data, 32'h0000007F);
                check("bufaddr1", Buf_address, 1);
            end
        end
        check("we_count", nwe, 64);
        check("ready_lat", rdy_at, 66);
`ifdef SRAM_BLOCK_FETCH_PINGPONG_EN
        flag = 0; seen = 0;
        for (int i = 0; i < 150; i++) begin
            tick;
            if (Buf_we && Buf_address[6]) flag = 1;
            if (Block_ready) seen = 1;
        end
        check("pp_bank1", flag, 1);
        check("pp_hold", seen, 0);
        Consumer_ack = 1'b1;
        tick;
        Consumer_ack = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick;
            if (Block_ready) seen = 1;
        end
        check("pp_release", seen, 1);
        Reset = 1'b1;
        tick;
        Reset = 1'b0;
`else
        Consumer_ack = 1'b1;
        tick;
        Consumer_ack = 1'b0;
        flag = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (SRAM_address != 0 || Block_ready) flag = 1;
        end
        check("no_issue_before_ack", flag, 0);
        check("still_busy", Busy, 1);
        Consumer_ack = 1'b1;
        tick;
        Consumer_ack = 1'b0;
        for (int b = 1; b < 120; b++) begin
            fetch(first, last, nwe, niss);
            if (b == 1) check("blk1_first", first, 76808);
            if (b == 40) check("blk40_first", first, 79360);
            if (b == 119) begin
                check("lastblk_first", first, 82232);
                check("lastblk_last", last, 84479);
                check("lastblk_iss", niss, 64);
                check("lastblk_we", nwe, 64);
            end
            ack;
        end
        check("done_pulse", {Done, Busy}, 2'b11);
        tick;
        check("done_clear", {Done, Busy}, 2'b00);
`endif
        Enable = 1'b1;
        cnt = 0; pa = 0; seen = 0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            tick;
            Enable = 1'b0;
            if (SRAM_address != 0) cnt++;
            if (cnt == 3*64 + 21) begin
                seen = 1;
                Reset = 1'b1;
            end
            if (Block_ready) pa = 2;
            else if (pa > 0) pa--;
            Consumer_ack = pa == 1;
        end
        check("reach_blk3", seen, 1);
        tick;
        Reset = 1'b0;
        Consumer_ack = 1'b0;
        check("mid_rst_outs", {Busy, Buf_we, Block_ready, Done}, 0);
        check("mid_rst_addr", SRAM_address, 0);
        check("mid_rst_bufaddr", Buf_address, 0);
        flag = 0;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (Buf_we) flag = 1;
        end
        check("no_we_after_rst", flag, 0);
        Enable = 1'b1;
        tick;
        Enable = 1'b0;
        check("restart_addr", SRAM_address, 76800);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
